// File: rtl/audio_pkg.sv
// audio_pkg: shared widths and scheduler state encoding for the audio DDR path.
package audio_pkg;
    localparam int AUDIO_WORD_W   = 64;
    localparam int DEFAULT_ADDR_W = 20;
    typedef enum logic [2:0] {ST_IDLE, ST_WR_CMD, ST_RD_CMD, ST_RD_WAIT, ST_ZERO} state_t;
endpackage

// File: rtl/audio_wr_fifo.sv
// audio_wr_fifo: record-side frame FIFO; push on a full FIFO is legal only alongside a pop.
module audio_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (push && !flush) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/audio_ddr_sched.sv
// audio_ddr_sched: arbitrates the single DDR user port between record writes and looping playback reads.
module audio_ddr_sched import audio_pkg::*; #(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] REC_LAST = {ADDR_W{1'b1}},
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock_50M,
    input  logic                    reset,
    input  logic                    rec_en,
    input  logic                    play_en,
    input  logic [AUDIO_WORD_W-1:0] wav_in_data,
    input  logic                    wav_wren,
    input  logic                    play_req,
    output logic [AUDIO_WORD_W-1:0] play_data,
    output logic                    play_valid,
    output logic                    mem_cmd_valid,
    input  logic                    mem_cmd_ready,
    output logic                    mem_cmd_we,
    output logic [ADDR_W-1:0]       mem_cmd_addr,
    output logic [AUDIO_WORD_W-1:0] mem_wr_data,
    input  logic                    mem_rd_valid,
    input  logic [AUDIO_WORD_W-1:0] mem_rd_data,
    output logic [ADDR_W:0]         rec_words,
    output logic                    rec_full,
    output logic                    wr_overflow,
    output logic                    rd_drop,
    output logic                    busy
);
    localparam logic [ADDR_W:0] REC_MAX = {1'b0, REC_LAST} + 1'b1;
    state_t state, state_d;
    logic rec_q, play_q, rec_rise, play_rise;
    logic fifo_full, fifo_empty, push, pop, can_write, req_ok, rd_busy, rd_ret;
    logic [AUDIO_WORD_W-1:0] head, cmd_data;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic rd_pend;
    assign rec_rise = rec_en && !rec_q;
    assign play_rise = play_en && !play_q;
    assign can_write = wav_wren && rec_en && !rec_full;
    // The in-flight write stays in the FIFO until accepted, so it counts against the depth.
    assign pop = (state == ST_WR_CMD && mem_cmd_ready) || (state == ST_IDLE && !fifo_empty && rec_full);
    assign push = can_write && (!fifo_full || pop);
    assign rd_busy = state == ST_RD_CMD || state == ST_RD_WAIT;
    assign req_ok = play_req && play_en && !rd_pend && !rd_busy;
    assign rd_ret = state == ST_RD_WAIT && mem_rd_valid && play_en;
    assign mem_cmd_valid = state == ST_WR_CMD || state == ST_RD_CMD;
    assign mem_cmd_we = state == ST_WR_CMD;
    assign mem_cmd_addr = mem_cmd_we ? wr_addr : rd_addr;
    assign mem_wr_data = cmd_data;
    assign busy = state != ST_IDLE;
    audio_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(AUDIO_WORD_W)) u_fifo (
        .clk(clock_50M), .rst(reset), .flush(rec_rise), .push(push), .pop(pop),
        .din(wav_in_data), .head(head), .full(fifo_full), .empty(fifo_empty)
    );
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    state_d = (!fifo_empty && !rec_full && !rec_rise) ? ST_WR_CMD :
                                  (rd_pend && play_en) ? (rec_words == '0 ? ST_ZERO : ST_RD_CMD) : ST_IDLE;
            ST_WR_CMD:  state_d = mem_cmd_ready ? ST_IDLE : ST_WR_CMD;
            ST_RD_CMD:  state_d = mem_cmd_ready ? ST_RD_WAIT : ST_RD_CMD;
            ST_RD_WAIT: state_d = mem_rd_valid ? ST_IDLE : ST_RD_WAIT;
            default:    state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clock_50M or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else state <= state_d;
    end
    always_ff @(posedge clock_50M or posedge reset) begin
        if (reset) begin
            rec_q <= 1'b0;
            play_q <= 1'b0;
            cmd_data <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            rec_words <= '0;
            rec_full <= 1'b0;
            wr_overflow <= 1'b0;
            rd_pend <= 1'b0;
            rd_drop <= 1'b0;
            play_valid <= 1'b0;
            play_data <= '0;
        end else begin
            rec_q <= rec_en;
            play_q <= play_en;
            if (state == ST_IDLE && state_d == ST_WR_CMD) cmd_data <= head;
            if (rec_rise) begin
                wr_addr <= '0;
                rec_words <= '0;
                rec_full <= 1'b0;
                wr_overflow <= 1'b0;
            end else begin
                if (can_write && fifo_full && !pop) wr_overflow <= 1'b1;
                if (state == ST_WR_CMD && mem_cmd_ready) begin
                    wr_addr <= wr_addr + 1'b1;
                    if (rec_words != REC_MAX) rec_words <= rec_words + 1'b1;
                    if (wr_addr == REC_LAST) rec_full <= 1'b1;
                end
            end
            // Wrap against the live word count so playback follows an ongoing recording.
            if (play_rise) rd_addr <= '0;
            else if (state == ST_RD_CMD && mem_cmd_ready)
                rd_addr <= ({1'b0, rd_addr} + 1'b1 >= rec_words) ? '0 : rd_addr + 1'b1;
            if (!play_en) rd_pend <= 1'b0;
            else if (req_ok) rd_pend <= 1'b1;
            else if ((state == ST_RD_CMD && mem_cmd_ready) || state == ST_ZERO) rd_pend <= 1'b0;
            if (play_rise) rd_drop <= 1'b0;
            if (play_req && !req_ok) rd_drop <= 1'b1;
            play_valid <= state == ST_ZERO || rd_ret;
            if (state == ST_ZERO) play_data <= '0;
            else if (rd_ret) play_data <= mem_rd_data;
        end
    end
endmodule

// File: tb/tb_audio_ddr_sched.sv
// tb_audio_ddr_sched: directed stimulus with a scoreboard of expected DDR commands and playback words.
module tb_audio_ddr_sched;
    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [63:0] data;
    } cmd_t;

    logic        clock_50M = 1'b0;
    logic        reset = 1'b1;
    logic        rec_en = 1'b0, play_en = 1'b0, wav_wren = 1'b0, play_req = 1'b0;
    logic [63:0] wav_in_data = '0;
    logic [63:0] play_data;
    logic        play_valid, mem_cmd_valid, mem_cmd_we;
    logic        mem_cmd_ready = 1'b0, mem_rd_valid = 1'b0;
    logic [19:0] mem_cmd_addr;
    logic [63:0] mem_wr_data, mem_rd_data = '0;
    logic [20:0] rec_words;
    logic        rec_full, wr_overflow, rd_drop, busy;

    cmd_t        exp_cmd[$];
    logic [63:0] exp_play[$];
    int          checks = 0, errors = 0;

    audio_ddr_sched #(.ADDR_W(20), .REC_LAST(20'd3), .FIFO_DEPTH(4)) dut (
        .clock_50M(clock_50M), .reset(reset), .rec_en(rec_en), .play_en(play_en),
        .wav_in_data(wav_in_data), .wav_wren(wav_wren), .play_req(play_req),
        .play_data(play_data), .play_valid(play_valid), .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .rec_words(rec_words), .rec_full(rec_full), .wr_overflow(wr_overflow),
        .rd_drop(rd_drop), .busy(busy)
    );

    always #5 clock_50M = ~clock_50M;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_50M);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic frame(input logic [63:0] d);
        wav_in_data = d;
        wav_wren = 1'b1;
        tick(1);
        wav_wren = 1'b0;
    endtask

    task automatic req();
        play_req = 1'b1;
        tick(1);
        play_req = 1'b0;
    endtask

    task automatic exp_wr(input logic [19:0] a, input logic [63:0] d);
        exp_cmd.push_back('{1'b1, a, d});
    endtask

    task automatic exp_rd(input logic [19:0] a);
        exp_cmd.push_back('{1'b0, a, 64'd0});
        exp_play.push_back(64'd100 + 64'(a));
    endtask

    task automatic restart_rec();
        rec_en = 1'b0;
        tick(1);
        rec_en = 1'b1;
        tick(2);
    endtask

    // Monitor: inputs change just after posedge, so negedge sees what the next edge will sample.
    always @(negedge clock_50M) begin
        if (mem_cmd_valid && mem_cmd_ready) begin
            checks++;
            if (exp_cmd.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd got we=%0b addr=%0d expected none", mem_cmd_we, mem_cmd_addr);
            end else begin
                cmd_t e;
                e = exp_cmd.pop_front();
                if (mem_cmd_we !== e.we || mem_cmd_addr !== e.addr || (e.we && mem_wr_data !== e.data)) begin
                    errors++;
                    $display("FAIL cmd got we=%0b addr=%0d data=%0h expected we=%0b addr=%0d data=%0h",
                             mem_cmd_we, mem_cmd_addr, mem_wr_data, e.we, e.addr, e.data);
                end
            end
        end
        if (play_valid) begin
            checks++;
            if (exp_play.size() == 0) begin
                errors++;
                $display("FAIL unexpected_play got %0h expected none", play_data);
            end else begin
                logic [63:0] p;
                p = exp_play.pop_front();
                if (play_data !== p) begin
                    errors++;
                    $display("FAIL play_data got %0h expected %0h", play_data, p);
                end
            end
        end
    end

    // DDR read model: returns addr+100 two cycles after the read is accepted.
    initial begin
        logic [19:0] a;
        forever begin
            @(negedge clock_50M);
            if (mem_cmd_valid && mem_cmd_ready && !mem_cmd_we) begin
                a = mem_cmd_addr;
                tick(3);
                mem_rd_valid = 1'b1;
                mem_rd_data = 64'd100 + 64'(a);
                tick(1);
                mem_rd_valid = 1'b0;
            end
        end
    end

    initial begin
        tick(2);
        check("rst_valid", 64'(mem_cmd_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_words", 64'(rec_words), 64'd0);
        check("rst_flags", {rec_full, wr_overflow, rd_drop, play_valid}, 64'd0);
        reset = 1'b0;

        // Reset while a write waits for ready
        rec_en = 1'b1;
        tick(2);
        frame(64'hEEEE_0000_0000_0001);
        frame(64'hEEEE_0000_0000_0002);
        check("pre_reset_valid", 64'(mem_cmd_valid), 64'd1);
        #3 reset = 1'b1;
        #1 check("async_reset_valid", 64'(mem_cmd_valid), 64'd0);
        rec_en = 1'b0;
        tick(2);
        reset = 1'b0;
        check("post_reset_words", 64'(rec_words), 64'd0);
        mem_cmd_ready = 1'b1;
        tick(10);
        check("post_reset_idle", 64'(busy), 64'd0);

        // Three writes, ready always high
        rec_en = 1'b1;
        tick(2);
        exp_wr(20'd0, 64'hAAAA_AAAA_0000_0000);
        exp_wr(20'd1, 64'hBBBB_BBBB_0000_0001);
        exp_wr(20'd2, 64'hCCCC_CCCC_0000_0002);
        frame(64'hAAAA_AAAA_0000_0000);
        check("wr_latency_n1", 64'(mem_cmd_valid), 64'd0);
        tick(1);
        check("wr_latency_n2", 64'(mem_cmd_valid), 64'd1);
        frame(64'hBBBB_BBBB_0000_0001);
        frame(64'hCCCC_CCCC_0000_0002);
        tick(8);
        check("three_words", 64'(rec_words), 64'd3);

        // Ready stalled: four words fit, the rest overflow
        mem_cmd_ready = 1'b0;
        restart_rec();
        check("restart_words", 64'(rec_words), 64'd0);
        for (int i = 0; i < 4; i++) exp_wr(20'(i), 64'hD000_0000_0000_0000 + 64'(i));
        for (int i = 0; i < 6; i++) frame(64'hD000_0000_0000_0000 + 64'(i));
        tick(34);
        check("overflow", 64'(wr_overflow), 64'd1);
        mem_cmd_ready = 1'b1;
        tick(12);
        check("stall_words", 64'(rec_words), 64'd4);

        // Region exhausted at REC_LAST=3
        restart_rec();
        check("full_cleared", {rec_full, wr_overflow}, 64'd0);
        for (int i = 0; i < 4; i++) exp_wr(20'(i), 64'hF000_0000_0000_0000 + 64'(i));
        for (int i = 0; i < 5; i++) begin
            frame(64'hF000_0000_0000_0000 + 64'(i));
            tick(3);
        end
        tick(5);
        check("full_words", 64'(rec_words), 64'd4);
        check("rec_full", 64'(rec_full), 64'd1);
        check("full_no_overflow", 64'(wr_overflow), 64'd0);

        // Playback loops over three recorded words
        restart_rec();
        for (int i = 0; i < 3; i++) exp_wr(20'(i), 64'h6000_0000_0000_0000 + 64'(i));
        for (int i = 0; i < 3; i++) begin
            frame(64'h6000_0000_0000_0000 + 64'(i));
            tick(3);
        end
        rec_en = 1'b0;
        play_en = 1'b1;
        tick(2);
        exp_rd(20'd0);
        exp_rd(20'd1);
        exp_rd(20'd2);
        exp_rd(20'd0);
        req();
        check("rd_latency_n1", 64'(mem_cmd_valid), 64'd0);
        tick(1);
        check("rd_latency_n2", {mem_cmd_valid, mem_cmd_we}, 64'b10);
        tick(10);
        for (int i = 0; i < 3; i++) begin
            req();
            tick(10);
        end
        check("no_drop", 64'(rd_drop), 64'd0);

        // Empty recording plays zero without touching DDR
        restart_rec();
        play_en = 1'b0;
        tick(1);
        play_en = 1'b1;
        tick(2);
        exp_play.push_back(64'd0);
        req();
        tick(5);

        // Request during RD_WAIT is dropped
        exp_wr(20'd0, 64'h1111_0000_0000_0000);
        frame(64'h1111_0000_0000_0000);
        tick(5);
        exp_rd(20'd0);
        req();
        tick(2);
        req();
        check("rd_drop", 64'(rd_drop), 64'd1);
        tick(6);

        // Simultaneous write and read: write goes first
        exp_wr(20'd1, 64'h2222_0000_0000_0001);
        exp_rd(20'd0);
        wav_in_data = 64'h2222_0000_0000_0001;
        wav_wren = 1'b1;
        play_req = 1'b1;
        tick(1);
        wav_wren = 1'b0;
        play_req = 1'b0;
        tick(14);

        check("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
        check("play_queue_drained", 64'(exp_play.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
